// File: rtl/common_types_pkg.sv
// rtl/common_types_pkg.sv - shared types and constants for the machine-mode trap sequencer
package common_types_pkg;

  localparam int WORD_W         = 32;
  localparam int MCAUSE_INT_BIT = 31;

  localparam logic [WORD_W-1:0] CAUSE_MSI        = 32'd3;
  localparam logic [WORD_W-1:0] CAUSE_MTI        = 32'd7;
  localparam logic [WORD_W-1:0] CAUSE_MEI        = 32'd11;
  localparam logic [WORD_W-1:0] CAUSE_LOCAL_BASE = 32'd16;

  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

  typedef enum logic [1:0] {IDLE, FLUSH, TRAP} trap_state_t;
  typedef enum logic {EXC, INT} trap_kind_t;

  // Vectored mode only applies to interrupts; the shift drops the interrupt flag bit.
  function automatic logic [WORD_W-1:0] trap_target(input logic [WORD_W-1:0] tvec,
                                                    input trap_kind_t        kind,
                                                    input logic [WORD_W-1:0] cause);
    logic [WORD_W-1:0] base;
    base = {tvec[WORD_W-1:2], 2'b00};
    if (tvec[1:0] == MTVEC_MODE_VECTORED && kind == INT) begin
      return base + (cause << 2);
    end
    return base;
  endfunction

endpackage

// File: rtl/irq_sync.sv
// rtl/irq_sync.sv - N-stage async-reset bit synchronizer for one interrupt line
module irq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/trap_controller.sv
// rtl/trap_controller.sv - machine-mode trap sequencer: arbitrate, drain, pulse trap entry, redirect
module trap_controller
  import common_types_pkg::*;
#(
  parameter int NUM_LOCAL_IRQ = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     irq_ext,
  input  logic                     irq_soft,
  input  logic                     irq_timer,
  input  logic [NUM_LOCAL_IRQ-1:0] irq_local,
  input  logic                     csr_mie,
  input  logic [WORD_W-1:0]        mtvec,
  input  logic [WORD_W-1:0]        mepc,
  input  logic                     exc_valid,
  input  logic [WORD_W-1:0]        exc_cause,
  input  logic [WORD_W-1:0]        exc_pc,
  input  logic                     mret,
  input  logic                     pipe_drained,
  input  logic [WORD_W-1:0]        resume_pc,
  output logic                     halt_req,
  output logic                     redirect_valid,
  output logic [WORD_W-1:0]        redirect_pc,
  output logic                     csr_exception,
  output logic [WORD_W-1:0]        csr_exception_cause,
  output logic [WORD_W-1:0]        csr_exception_pc,
  output logic                     busy
);

  logic                     irq_ext_s;
  logic                     irq_soft_s;
  logic                     irq_timer_s;
  logic [NUM_LOCAL_IRQ-1:0] irq_local_s;

  irq_sync #(.STAGES(SYNC_STAGES)) u_sync_ext   (.clk(CLK), .rst_n(nRST), .d(irq_ext),   .q(irq_ext_s));
  irq_sync #(.STAGES(SYNC_STAGES)) u_sync_soft  (.clk(CLK), .rst_n(nRST), .d(irq_soft),  .q(irq_soft_s));
  irq_sync #(.STAGES(SYNC_STAGES)) u_sync_timer (.clk(CLK), .rst_n(nRST), .d(irq_timer), .q(irq_timer_s));

  for (genvar i = 0; i < NUM_LOCAL_IRQ; i++) begin : g_local_sync
    irq_sync #(.STAGES(SYNC_STAGES)) u_sync_local (
      .clk  (CLK),
      .rst_n(nRST),
      .d    (irq_local[i]),
      .q    (irq_local_s[i])
    );
  end

  logic              irq_pend;
  logic [WORD_W-1:0] win_cause;

  assign irq_pend = irq_ext_s | irq_soft_s | irq_timer_s | (|irq_local_s);

  // Later assignments win: walk from lowest to highest priority.
  always_comb begin
    win_cause = '0;
    for (int i = NUM_LOCAL_IRQ - 1; i >= 0; i--) begin
      if (irq_local_s[i]) win_cause = CAUSE_LOCAL_BASE + WORD_W'(i);
    end
    if (irq_timer_s) win_cause = CAUSE_MTI;
    if (irq_soft_s)  win_cause = CAUSE_MSI;
    if (irq_ext_s)   win_cause = CAUSE_MEI;
    win_cause[MCAUSE_INT_BIT] = 1'b1;
  end

  trap_state_t       state_q, state_d;
  trap_kind_t        kind_q, kind_d;
  logic [WORD_W-1:0] cause_q, cause_d;
  logic [WORD_W-1:0] pc_q, pc_d;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      kind_q  <= EXC;
      cause_q <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      cause_q <= cause_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    kind_d              = kind_q;
    cause_d             = cause_q;
    pc_d                = pc_q;
    halt_req            = 1'b0;
    redirect_valid      = 1'b0;
    redirect_pc         = '0;
    csr_exception       = 1'b0;
    csr_exception_cause = '0;
    csr_exception_pc    = '0;

    case (state_q)
      IDLE: begin
        if (exc_valid) begin
          kind_d  = EXC;
          cause_d = exc_cause;
          pc_d    = exc_pc;
          state_d = FLUSH;
        end else if (irq_pend && csr_mie) begin
          kind_d  = INT;
          cause_d = win_cause;
          state_d = FLUSH;
        end else if (mret && nRST) begin
          redirect_valid = 1'b1;
          redirect_pc    = mepc;
        end
      end

      FLUSH: begin
        halt_req = 1'b1;
        // A synchronous fault found while draining outranks the pending interrupt.
        if (exc_valid && kind_q == INT) begin
          kind_d  = EXC;
          cause_d = exc_cause;
          pc_d    = exc_pc;
        end
        if (pipe_drained) begin
          if (kind_d == INT) pc_d = resume_pc;
          state_d = TRAP;
        end
      end

      TRAP: begin
        halt_req            = 1'b1;
        csr_exception       = 1'b1;
        csr_exception_cause = cause_q;
        csr_exception_pc    = pc_q;
        redirect_valid      = 1'b1;
        redirect_pc         = trap_target(mtvec, kind_q, cause_q);
        state_d             = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_trap_controller.sv
// tb/tb_trap_controller.sv - self-checking bench for trap_controller
module tb_trap_controller;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        irq_ext, irq_soft, irq_timer;
  logic [3:0]  irq_local;
  logic        csr_mie;
  logic [31:0] mtvec, mepc, exc_cause, exc_pc, resume_pc;
  logic        exc_valid, mret, pipe_drained;
  logic        halt_req, redirect_valid, csr_exception, busy;
  logic [31:0] redirect_pc, csr_exception_cause, csr_exception_pc;

  trap_controller #(.NUM_LOCAL_IRQ(4), .SYNC_STAGES(2)) dut (
    .CLK                (CLK),
    .nRST               (nRST),
    .irq_ext            (irq_ext),
    .irq_soft           (irq_soft),
    .irq_timer          (irq_timer),
    .irq_local          (irq_local),
    .csr_mie            (csr_mie),
    .mtvec              (mtvec),
    .mepc               (mepc),
    .exc_valid          (exc_valid),
    .exc_cause          (exc_cause),
    .exc_pc             (exc_pc),
    .mret               (mret),
    .pipe_drained       (pipe_drained),
    .resume_pc          (resume_pc),
    .halt_req           (halt_req),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc),
    .csr_exception      (csr_exception),
    .csr_exception_cause(csr_exception_cause),
    .csr_exception_pc   (csr_exception_pc),
    .busy               (busy)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Reference rules: priority ext > soft > timer > local (lowest index).
  function automatic logic [31:0] model_cause(input logic [6:0] irqs);
    if (irqs[6]) return 32'h8000000B;
    if (irqs[5]) return 32'h80000003;
    if (irqs[4]) return 32'h80000007;
    for (int i = 0; i < 4; i++) if (irqs[i]) return 32'h80000000 + 32'(16 + i);
    return 32'h0;
  endfunction

  function automatic logic [31:0] model_target(input logic [31:0] tv, input bit is_int,
                                               input logic [31:0] cause);
    logic [31:0] base;
    base = tv & 32'hFFFFFFFC;
    if (is_int && tv[1:0] == 2'b01) return base + (cause & 32'h7FFFFFFF) * 32'd4;
    return base;
  endfunction

  task automatic set_irqs(input logic [6:0] v);
    {irq_ext, irq_soft, irq_timer, irq_local} = v;
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Steps from the current drive window; pipe_drained rises at step d, optional exc_valid at step ov_at.
  task automatic wait_pulse(input int max_cyc, input int d, input int ov_at, output bit seen,
                            output int lat, output logic [31:0] c, output logic [31:0] p,
                            output logic [31:0] t, output logic rv, output logic hr);
    seen = 0; lat = -1; c = '0; p = '0; t = '0; rv = 0; hr = 0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge CLK);
      if (csr_exception) begin
        seen = 1; lat = i; c = csr_exception_cause; p = csr_exception_pc;
        t = redirect_pc; rv = redirect_valid; hr = halt_req;
      end
      cyc();
      if (!seen) begin
        pipe_drained = (i + 1 >= d);
        exc_valid    = (ov_at != 0) && (i + 1 == ov_at);
      end
    end
    csr_mie = 0; set_irqs('0); exc_valid = 0; mret = 0; pipe_drained = 1;
  endtask

  task automatic finish_trap(input string nm, input bit seen, input int lat, input logic [31:0] c,
                             input logic [31:0] p, input logic [31:0] t, input logic rv,
                             input logic hr, input logic [31:0] ec, input logic [31:0] ep,
                             input logic [31:0] et, input int el);
    chk({nm, "_seen"}, 32'(seen), 32'd1);
    chk({nm, "_cause"}, c, ec);
    chk({nm, "_pc"}, p, ep);
    chk({nm, "_target"}, t, et);
    chk({nm, "_rv"}, 32'(rv), 32'd1);
    chk({nm, "_halt"}, 32'(hr), 32'd1);
    chk({nm, "_latency"}, 32'(lat), 32'(el));
    @(negedge CLK);
    chk({nm, "_single_pulse"}, 32'(csr_exception), 32'd0);
    chk({nm, "_busy_after"}, 32'(busy), 32'd0);
    chk({nm, "_idle_outs"}, csr_exception_cause | csr_exception_pc | redirect_pc, 32'd0);
    repeat (4) cyc();
  endtask

  task automatic run_int(input string nm, input logic [6:0] irqs, input logic [31:0] tv,
                         input logic [31:0] rpc, input int d, input int ov_at,
                         input logic [31:0] oc, input logic [31:0] op, input logic [31:0] ec,
                         input logic [31:0] ep, input logic [31:0] et, input int el);
    bit seen; int lat; logic [31:0] c, p, t; logic rv, hr;
    mtvec = tv; resume_pc = rpc; exc_cause = oc; exc_pc = op;
    pipe_drained = (d == 0); exc_valid = 0; csr_mie = 1;
    set_irqs(irqs);
    wait_pulse(40, d, ov_at, seen, lat, c, p, t, rv, hr);
    finish_trap(nm, seen, lat, c, p, t, rv, hr, ec, ep, et, el);
  endtask

  task automatic run_exc(input string nm, input logic [31:0] cause, input logic [31:0] pc,
                         input logic [31:0] tv, input int d, input bit with_mret, input int ov_at,
                         input logic [31:0] dc, input logic [31:0] dp);
    bit seen; int lat; logic [31:0] c, p, t; logic rv, hr;
    mtvec = tv; exc_cause = cause; exc_pc = pc; mepc = 32'hDEAD0000;
    pipe_drained = (d == 0); exc_valid = 1; mret = with_mret;
    @(negedge CLK);
    chk({nm, "_mret_dropped"}, 32'(redirect_valid), 32'd0);
    cyc();
    exc_valid = 0; mret = 0; exc_cause = dc; exc_pc = dp;
    wait_pulse(40, d, ov_at, seen, lat, c, p, t, rv, hr);
    finish_trap(nm, seen, lat, c, p, t, rv, hr, cause, pc, model_target(tv, 0, cause), d + 1);
  endtask

  typedef struct {
    logic [6:0]  irqs;
    logic [31:0] tv;
    logic [31:0] rpc;
    logic [31:0] cause;
    logic [31:0] tgt;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int cnt;
    bit seen; int lat; logic [31:0] c, p, t; logic rv, hr;

    tbl[0] = '{7'b0010000, 32'h00000401, 32'h340, 32'h80000007, 32'h0000041C};
    tbl[1] = '{7'b1100100, 32'h00000200, 32'h500, 32'h8000000B, 32'h00000200};
    tbl[2] = '{7'b0001100, 32'h00001000, 32'h600, 32'h80000012, 32'h00001000};
    tbl[3] = '{7'b1111111, 32'h00000403, 32'h700, 32'h8000000B, 32'h00000400};
    tbl[4] = '{7'b0110000, 32'h00000101, 32'h800, 32'h80000003, 32'h0000010C};
    tbl[5] = '{7'b0000001, 32'hFFFFFFFD, 32'h900, 32'h80000010, 32'h0000003C};
    tbl[6] = '{7'b0001000, 32'h00000801, 32'hA00, 32'h80000013, 32'h0000084C};

    nRST = 0; set_irqs('0); csr_mie = 0; mtvec = '0; mepc = '0; exc_valid = 0;
    exc_cause = '0; exc_pc = '0; mret = 0; pipe_drained = 1; resume_pc = '0;
    repeat (2) cyc();
    chk("reset_halt", 32'(halt_req), 0);
    chk("reset_rv", 32'(redirect_valid), 0);
    chk("reset_exc", 32'(csr_exception), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_buses", redirect_pc | csr_exception_cause | csr_exception_pc, 0);
    nRST = 1;
    repeat (2) cyc();

    run_exc("illegal", 32'h2, 32'h100, 32'h200, 0, 0, 0, 32'h0, 32'h0);

    for (int i = 0; i < 7; i++)
      run_int($sformatf("tbl%0d", i), tbl[i].irqs, tbl[i].tv, tbl[i].rpc, 0, 0, 0, 0,
              tbl[i].cause, tbl[i].rpc, tbl[i].tgt, 4);

    // Masked interrupt must not halt the pipeline; enabling mie then traps.
    csr_mie = 0; set_irqs(7'b1000000); resume_pc = 32'h5A0; mtvec = 32'h300; cnt = 0;
    repeat (20) begin
      @(negedge CLK);
      if (halt_req || busy) cnt++;
      cyc();
    end
    chk("mask_no_halt", 32'(cnt), 0);
    csr_mie = 1;
    wait_pulse(20, 0, 0, seen, lat, c, p, t, rv, hr);
    finish_trap("mask_release", seen, lat, c, p, t, rv, hr, 32'h8000000B, 32'h5A0, 32'h300, 2);

    run_int("override", 7'b0010000, 32'h401, 32'h340, 7, 6, 32'h8, 32'h88,
            32'h8, 32'h88, 32'h400, 8);
    run_exc("late_exc_ignored", 32'h5, 32'h2000, 32'h401, 3, 1, 2, 32'hD, 32'h3000);

    // Reset asserted while draining aborts the trap with no pulse.
    mtvec = 32'h200; exc_cause = 32'h4; exc_pc = 32'h44; pipe_drained = 0; exc_valid = 1;
    cyc();
    exc_valid = 0;
    @(negedge CLK);
    chk("flush_halt", 32'(halt_req), 1);
    cyc();
    nRST = 0;
    #1;
    chk("async_rst_halt", 32'(halt_req), 0);
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_exc", 32'({csr_exception, redirect_valid}), 0);
    pipe_drained = 1;
    repeat (2) cyc();
    nRST = 1;
    cnt = 0;
    repeat (6) begin
      @(negedge CLK);
      if (csr_exception || busy) cnt++;
      cyc();
    end
    chk("rst_no_pulse", 32'(cnt), 0);

    mepc = 32'h1234; mret = 1;
    @(negedge CLK);
    chk("mret_rv", 32'(redirect_valid), 1);
    chk("mret_pc", redirect_pc, 32'h1234);
    chk("mret_no_exc", 32'(csr_exception), 0);
    cyc();
    mret = 0;
    @(negedge CLK);
    chk("mret_rv_drop", 32'(redirect_valid), 0);
    chk("mret_pc_zero", redirect_pc, 0);
    cyc();

    for (int n = 0; n < 30; n++) begin
      logic [31:0] tv, rc, rp, ec;
      logic [6:0]  irqs;
      int          d, last, ov;
      tv = $urandom;
      if ($urandom_range(0, 1) == 1) tv[1:0] = 2'b01;
      if ($urandom_range(0, 1) == 1) begin
        rc = $urandom & 32'h7FFFFFFF; rp = $urandom; d = int'($urandom_range(0, 4));
        run_exc("rnd_exc", rc, rp, tv, d, 1'($urandom_range(0, 1)), 0, 32'h0, 32'h0);
      end else begin
        irqs = 7'($urandom_range(1, 127)); rp = $urandom; d = int'($urandom_range(0, 6));
        last = (d > 3) ? d : 3;
        if ($urandom_range(0, 3) == 0) begin
          ov = int'($urandom_range(3, last)); rc = $urandom & 32'h7FFFFFFF; ec = $urandom;
          run_int("rnd_ovr", irqs, tv, rp, d, ov, rc, ec, rc, ec, model_target(tv, 0, rc), last + 1);
        end else begin
          ec = model_cause(irqs);
          run_int("rnd_int", irqs, tv, rp, d, 0, 0, 0, ec, rp, model_target(tv, 1, ec), last + 1);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/trap_controller.md
Name: trap_controller

Overview:
- Machine-mode trap sequencer; sits directly upstream of the CSR file and drives its hardware-override inputs (`csr_exception`, `csr_exception_cause`, `csr_exception_pc`).
- Consumes the CSR file's `csr_mie` output.
- Arbitrates synchronous exceptions against asynchronous interrupts, drains the pipeline, then issues a single trap-entry pulse plus a PC redirect to mtvec.
- Also redirects to mepc on mret.

Parameters:
- `NUM_LOCAL_IRQ`, 4, number of platform-local interrupt lines (causes 16..16+N-1)
- `SYNC_STAGES`, 2, flip-flop depth of each interrupt-input synchronizer (min 2)

Ports:
- `CLK` in 1 — core clock
- `nRST` in 1 — asynchronous active-low reset
- `irq_ext` in 1 — machine external interrupt, async level
- `irq_soft` in 1 — machine software interrupt, async level
- `irq_timer` in 1 — machine timer interrupt, async level
- `irq_local` in NUM_LOCAL_IRQ — platform local interrupts, async level
- `csr_mie` in 1 — global interrupt enable from the CSR file
- `mtvec` in WORD_W — trap vector CSR value
- `mepc` in WORD_W — return address CSR value
- `exc_valid` in 1 — commit stage reports a synchronous exception
- `exc_cause` in WORD_W — exception code (bit 31 = 0)
- `exc_pc` in WORD_W — PC of the faulting instruction
- `mret` in 1 — commit stage retires an mret
- `pipe_drained` in 1 — pipeline is empty and fetch is halted
- `resume_pc` in WORD_W — PC of the oldest unretired instruction; valid when `pipe_drained` = 1
- `halt_req` out 1 — asks the pipeline to stop fetch and drain
- `redirect_valid` out 1 — one-cycle PC redirect strobe
- `redirect_pc` out WORD_W — redirect target
- `csr_exception` out 1 — one-cycle trap-entry pulse to the CSR file
- `csr_exception_cause` out WORD_W — mcause value
- `csr_exception_pc` out WORD_W — mepc value
- `busy` out 1 — FSM is not in IDLE

Behaviour:
- **Reset:**
  - Asynchronous; FSM returns to IDLE.
  - All outputs and latched cause/pc registers become 0; synchronizers are cleared.
  - Assertion mid-FLUSH or mid-TRAP aborts with no pulse.
- **Synchronization:** each irq input passes through a `SYNC_STAGES` synchronizer. Interrupts are level-sensitive, not latched before acceptance. `irq_pend` = any synchronized line high.
- **Interrupt priority (high to low):**
  - external → cause 0x8000000B
  - software → 0x80000003
  - timer → 0x80000007
  - `irq_local[i]` → 0x80000000 | (16+i), lowest i wins
  - A synchronous exception always beats an interrupt.
- **States:**
  - **IDLE**
    - `exc_valid` → latch `exc_cause`/`exc_pc`, kind = EXC, go to FLUSH.
    - Else `irq_pend` && `csr_mie` → latch the winning cause, kind = INT, go to FLUSH.
    - Else `mret` → `redirect_valid` = 1, `redirect_pc` = `mepc` for exactly this cycle; stay in IDLE.
    - `mret` with a simultaneous `exc_valid` is dropped (the exception wins).
  - **FLUSH**
    - `halt_req` = 1.
    - An `exc_valid` here with kind = INT overrides the latch: EXC cause/pc, kind = EXC.
    - A later `exc_valid` with kind already EXC is ignored.
    - Interrupt deassertion after acceptance does NOT cancel the trap.
    - On `pipe_drained`: if kind = INT, latch pc = `resume_pc`; go to TRAP.
    - No timeout.
  - **TRAP**
    - Exactly one cycle: `csr_exception` = 1, cause and pc driven from the latches, `redirect_valid` = 1, `halt_req` = 1.
    - Then go to IDLE.
- **Latency and re-trap:**
  - Minimum trap latency is 2 cycles after acceptance (FLUSH 1 cycle if already drained, then TRAP).
  - The CSR file clears mie on the `csr_exception` edge, so no re-trap occurs.
- **Redirect target:**
  - base = {mtvec[31:2], 2'b00}.
  - If mtvec[1:0] = 01 and kind = INT: target = base + 4 × (cause[30:0]), computed in 32 bits with wrap permitted.
  - Otherwise target = base.
  - mtvec[1:0] = 1x is treated as direct.
- **Idle outputs:** `redirect_pc` and the `csr_exception_*` outputs are 0 whenever their strobes are low.
- **Busy:** `busy` = (state != IDLE).

Decomposition:
- Shared package (`common_types_pkg`):
  - `trap_state_t` enum {IDLE, FLUSH, TRAP}
  - `trap_kind_t` {EXC, INT}
  - Constants: `MCAUSE_INT_BIT` = 31, `CAUSE_MSI` = 3, `CAUSE_MTI` = 7, `CAUSE_MEI` = 11, `CAUSE_LOCAL_BASE` = 16
  - `MTVEC_MODE_VECTORED` = 2'b01
- Sub-module: `irq_sync` (parameterised N-stage, async-reset bit synchronizer), instanced per interrupt line.

Test Plan:
- Illegal instruction: `exc_valid`, cause 2, pc 0x100, mtvec 0x200, `pipe_drained` already high → TRAP two cycles later; cause 0x2, pc 0x100, `redirect_pc` 0x200, `csr_exception` high 1 cycle.
- Vectored timer interrupt: mtvec 0x401, `csr_mie` = 1, `irq_timer` held; `resume_pc` 0x340 when drained → cause 0x80000007, pc 0x340, target 0x41C.
- Masking: `csr_mie` = 0 with `irq_ext` held 20 cycles → `halt_req` never rises. Raising `csr_mie` → trap with cause 0x8000000B.
- Priority: `irq_ext`, `irq_soft`, `irq_local[2]` simultaneous → cause 0x8000000B. With only `irq_local` = 4'b1100 → cause 0x80000012.
- Override: interrupt accepted, `pipe_drained` held low 3 cycles, then `exc_valid` cause 8 pc 0x88 → TRAP cause 0x8, pc 0x88, `redirect_pc` = base.
- Reset and mret: `nRST` low mid-FLUSH → all outputs 0 asynchronously, no pulse. Later `mret` with mepc 0x1234 → `redirect_valid` 1 cycle, `redirect_pc` 0x1234.
